// File: rtl/parking_occupancy_ctrl_pkg.sv
// Shared types and default constants for the parking occupancy controller.
// Optional feature macro used elsewhere in this slice: PARKING_EMPTY_TRIG_EN.
package parking_pkg;
   typedef enum logic {
      NOT_FULL = 1'b0,
      FULL     = 1'b1
   } state_t;

   localparam int DEF_CAPACITY        = 8;
   localparam int DEF_DEBOUNCE_CYCLES = 40000;
   localparam int SYNC_STAGES         = 2;
endpackage

// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor inputs and occupancy/pulse outputs of the parking occupancy controller.
// PARKING_EMPTY_TRIG_EN adds the empty_trigger pulse to the bundle.
interface parking_occupancy_ctrl_if
   import parking_pkg::*;
#(
   parameter int CAPACITY = DEF_CAPACITY
);
   localparam int CW = $clog2(CAPACITY + 1);

   logic          entry_sensor;
   logic          exit_sensor;
   logic [CW-1:0] count;
   logic          full;
   logic          full_trigger;
   logic          entry_ok;
   logic          entry_reject;
   logic          exit_err;
`ifdef PARKING_EMPTY_TRIG_EN
   logic          empty_trigger;

   modport master (
      output entry_sensor, exit_sensor,
      input  count, full, full_trigger, entry_ok, entry_reject, exit_err, empty_trigger
   );
   modport slave (
      input  entry_sensor, exit_sensor,
      output count, full, full_trigger, entry_ok, entry_reject, exit_err, empty_trigger
   );
`else
   modport master (
      output entry_sensor, exit_sensor,
      input  count, full, full_trigger, entry_ok, entry_reject, exit_err
   );
   modport slave (
      input  entry_sensor, exit_sensor,
      output count, full, full_trigger, entry_ok, entry_reject, exit_err
   );
`endif
endinterface

// File: rtl/parking_occupancy_ctrl_sensor_debounce.sv
// Loop sensor conditioning: synchroniser, stability counter, filtered level and
// a registered one-cycle pulse on each accepted rising level.
module sensor_debounce
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk_40MHz,
   input  logic reset,
   input  logic sensor,
   output logic rise
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] TERM = DW'(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync;
   logic [DW-1:0]          cnt;
   logic                   level;
   logic                   sensor_s;

   assign sensor_s = sync[SYNC_STAGES-1];

   // The level flips on the cycle the counter already sits at TERM and the
   // input still differs, so a change needs DEBOUNCE_CYCLES+1 stable samples.
   always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sensor};
         rise <= 1'b0;
         if (sensor_s == level) begin
            cnt <= '0;
         end else if (cnt == TERM) begin
            cnt   <= '0;
            level <= sensor_s;
            rise  <= sensor_s;
         end else begin
            cnt <= cnt + DW'(1);
         end
      end
   end
endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Occupancy counter and full/not-full FSM fed by two debounced loop sensors.
// Define PARKING_EMPTY_TRIG_EN to add the empty_trigger pulse (count 1 -> 0).
//
// state    | meaning
// NOT_FULL | count below CAPACITY, entries accepted
// FULL     | count == CAPACITY, entries rejected and flasher retriggered
module parking_occupancy_ctrl
   import parking_pkg::*;
#(
   parameter int CAPACITY        = DEF_CAPACITY,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic                     clk_40MHz,
   input  logic                     reset,
   parking_occupancy_ctrl_if.slave  bus
);
   localparam int CW = $clog2(CAPACITY + 1);
   localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);

   state_t        state, state_nxt;
   logic          entry_ev, exit_ev;
   logic [CW-1:0] count_r, count_nxt;
   logic          ok_nxt, rej_nxt, err_nxt, trig_nxt;
   logic          ok_r, rej_r, err_r, trig_r;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
      .clk_40MHz (clk_40MHz),
      .reset     (reset),
      .sensor    (bus.entry_sensor),
      .rise      (entry_ev)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
      .clk_40MHz (clk_40MHz),
      .reset     (reset),
      .sensor    (bus.exit_sensor),
      .rise      (exit_ev)
   );

   // Simultaneous entry and exit is a swap: count holds, driver admitted.
   always_comb begin
      count_nxt = count_r;
      ok_nxt    = 1'b0;
      rej_nxt   = 1'b0;
      err_nxt   = 1'b0;
      case ({entry_ev, exit_ev})
         2'b11: ok_nxt = 1'b1;
         2'b10: begin
            if (count_r < CAP_C) begin
               count_nxt = count_r + CW'(1);
               ok_nxt    = 1'b1;
            end else begin
               rej_nxt = 1'b1;
            end
         end
         2'b01: begin
            if (count_r != '0) count_nxt = count_r - CW'(1);
            else               err_nxt   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) state <= NOT_FULL;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         NOT_FULL: if (count_nxt == CAP_C) state_nxt = FULL;
         FULL:     if (count_nxt != CAP_C) state_nxt = NOT_FULL;
         default:  state_nxt = NOT_FULL;
      endcase
   end

   always_comb begin
      trig_nxt = 1'b0;
      case (state)
         NOT_FULL: trig_nxt = (state_nxt == FULL);
         FULL:     trig_nxt = rej_nxt;
         default:  trig_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) begin
         count_r <= '0;
         ok_r    <= 1'b0;
         rej_r   <= 1'b0;
         err_r   <= 1'b0;
         trig_r  <= 1'b0;
      end else begin
         count_r <= count_nxt;
         ok_r    <= ok_nxt;
         rej_r   <= rej_nxt;
         err_r   <= err_nxt;
         trig_r  <= trig_nxt;
      end
   end

   assign bus.count        = count_r;
   assign bus.full         = (state == FULL);
   assign bus.full_trigger = trig_r;
   assign bus.entry_ok     = ok_r;
   assign bus.entry_reject = rej_r;
   assign bus.exit_err     = err_r;

`ifdef PARKING_EMPTY_TRIG_EN
   logic empty_r;

   always_ff @(posedge clk_40MHz or posedge reset) begin
      if (reset) empty_r <= 1'b0;
      else       empty_r <= (count_r == CW'(1)) && (count_nxt == '0);
   end

   assign bus.empty_trigger = empty_r;
`endif
endmodule
